// File: rtl/sram_port_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sram_port_ctrl
// Description : Data/instruction request-response front end for a 1RW+1R SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [NUM_WMASKS-1:0] d_req_be,
  input  logic [31:0]           d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  input  logic                  d_rsp_ready,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic                  d_rsp_err,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [31:0]           i_req_addr,
  output logic                  i_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] i_rsp_rdata,
  output logic                  i_rsp_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RSP  = 2'd1;
  localparam logic [1:0] C_HOLD = 2'd2;

  logic [1:0]            r_d_state, w_d_state_nxt;
  logic [1:0]            r_i_state, w_i_state_nxt;
  logic                  r_d_err, r_d_rd, r_i_err;
  logic [DATA_WIDTH-1:0] r_d_hold, r_i_hold;

  logic                  w_d_inr, w_i_inr;
  logic [ADDR_WIDTH-1:0] w_d_word, w_i_word;
  logic                  w_d_fire, w_i_fire, w_d_access, w_i_access, w_conflict;
  logic                  w_unused_addr_bits;

  assign w_d_inr  = (d_req_addr[31:ADDR_WIDTH+2] == '0);
  assign w_i_inr  = (i_req_addr[31:ADDR_WIDTH+2] == '0);
  assign w_d_word = d_req_addr[ADDR_WIDTH+1:2];
  assign w_i_word = i_req_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr_bits = ^{d_req_addr[1:0], i_req_addr[1:0]};

  assign w_d_fire   = d_req_valid && d_req_ready;
  assign w_i_fire   = i_req_valid && i_req_ready;
  assign w_d_access = w_d_fire && w_d_inr;
  assign w_i_access = w_i_fire && w_i_inr;
  // A fetch of the word being written this cycle would see stale data; defer it one cycle.
  assign w_conflict = w_d_access && d_req_we && i_req_valid && w_i_inr && (w_i_word == w_d_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_state <= C_IDLE;
      r_i_state <= C_IDLE;
    end else begin
      r_d_state <= w_d_state_nxt;
      r_i_state <= w_i_state_nxt;
    end
  end

  always_comb begin
    w_d_state_nxt = C_IDLE;
    if (w_d_fire)
      w_d_state_nxt = C_RSP;
    else if ((r_d_state != C_IDLE) && !d_rsp_ready)
      w_d_state_nxt = C_HOLD;
    w_i_state_nxt = C_IDLE;
    if (w_i_fire)
      w_i_state_nxt = C_RSP;
    else if ((r_i_state != C_IDLE) && !i_rsp_ready)
      w_i_state_nxt = C_HOLD;
  end

  always_comb begin
    d_rsp_valid = (r_d_state != C_IDLE);
    i_rsp_valid = (r_i_state != C_IDLE);
    d_req_ready = !rst && (!d_rsp_valid || d_rsp_ready);
    i_req_ready = !rst && (!i_rsp_valid || i_rsp_ready) && !w_conflict;
    d_rsp_err   = d_rsp_valid && r_d_err;
    i_rsp_err   = i_rsp_valid && r_i_err;
    d_rsp_rdata = '0;
    i_rsp_rdata = '0;
    case (r_d_state)
      C_RSP:   d_rsp_rdata = r_d_rd ? dout0 : '0;
      C_HOLD:  d_rsp_rdata = r_d_hold;
      default: d_rsp_rdata = '0;
    endcase
    case (r_i_state)
      C_RSP:   i_rsp_rdata = r_i_err ? '0 : dout1;
      C_HOLD:  i_rsp_rdata = r_i_hold;
      default: i_rsp_rdata = '0;
    endcase
  end

  always_comb begin
    csb0   = !w_d_access;
    web0   = !(w_d_access && d_req_we);
    wmask0 = (w_d_access && d_req_we) ? d_req_be : '0;
    addr0  = w_d_access ? w_d_word : '0;
    din0   = (w_d_access && d_req_we) ? d_req_wdata : '0;
    csb1   = !w_i_access;
    addr1  = w_i_access ? w_i_word : '0;
  end

  // The SRAM output is only valid the cycle after access, so a stalled response is parked here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_err  <= 1'b0;
      r_d_rd   <= 1'b0;
      r_i_err  <= 1'b0;
      r_d_hold <= '0;
      r_i_hold <= '0;
    end else begin
      if (w_d_fire) begin
        r_d_err <= !w_d_inr;
        r_d_rd  <= w_d_inr && !d_req_we;
      end
      if (w_i_fire)
        r_i_err <= !w_i_inr;
      if ((r_d_state == C_RSP) && !d_rsp_ready)
        r_d_hold <= d_rsp_rdata;
      if ((r_i_state == C_RSP) && !i_rsp_ready)
        r_i_hold <= i_rsp_rdata;
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width (256 words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane count.
REQ-004 SHALL have clk  in  1  sole clock; also drives SRAM clk0/clk1 externally.
REQ-005 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have d_req_valid/d_req_ready  in/out  1  data-port request handshake.
REQ-007 SHALL have d_req_we  in  1 (1=write); d_req_be  in  NUM_WMASKS; d_req_addr  in  32 byte address; d_req_wdata  in  DATA_WIDTH.
REQ-008 SHALL have d_rsp_valid  out  1; d_rsp_ready  in  1; d_rsp_rdata  out  DATA_WIDTH; d_rsp_err  out  1.
REQ-009 SHALL have i_req_valid/i_req_ready  in/out  1; i_req_addr  in  32; i_rsp_valid  out  1; i_rsp_ready  in  1; i_rsp_rdata  out  DATA_WIDTH; i_rsp_err  out  1.
REQ-010 SHALL have csb0, web0  out  1; wmask0  out  NUM_WMASKS; addr0  out  ADDR_WIDTH; din0  out  DATA_WIDTH; dout0  in  DATA_WIDTH (SRAM RW port).
REQ-011 SHALL have csb1  out  1; addr1  out  ADDR_WIDTH; dout1  in  DATA_WIDTH (SRAM R port).

Function
REQ-012 SHALL map byte address to word address addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
REQ-013 SHALL flag a request out-of-range when addr[31:ADDR_WIDTH+2] != 0; such requests keep csb high, perform no SRAM access, and return err=1, rdata=0.
REQ-014 SHALL accept a request in the cycle valid&&ready; SRAM pins (csb=0, web, wmask, addr, din) driven combinationally in that same cycle N, otherwise csb=1, web0=1, wmask0=0.
REQ-015 SHALL raise rsp_valid in cycle N+1 for every accepted request (reads and writes); read rdata taken from dout0/dout1, write rdata=0, err=0 when in range.
REQ-016 SHALL drive d_req_ready = !d_rsp_valid || d_rsp_ready (same rule for i_ port); at most one outstanding request per port.
REQ-017 SHALL capture dout into a per-port hold register at the end of N+1 when rsp_valid && !rsp_ready, and present the held value until the handshake.
REQ-018 Each port SHALL run a 3-state FSM: IDLE (no rsp) -> RSP (rsp_valid, data from SRAM) -> HOLD (stalled, data from hold register); RSP->IDLE on rsp_ready with no new accept, RSP->RSP on rsp_ready with accept, RSP->HOLD on !rsp_ready; HOLD->IDLE/RSP likewise on rsp_ready.
REQ-019 SHALL block i_req_ready in a cycle where an i_ request targets the same word as a d_ write accepted in that cycle; fetch accepted next cycle and returns post-write data.
REQ-020 SHALL allow simultaneous d_ and i_ accepts to different words, or to the same word when the d_ request is a read.
REQ-021 SHALL pass d_req_be unmodified to wmask0 on writes; be=0 write is a legal no-op with normal response.

Reset
REQ-022 SHALL while rst=1 force csb0=1, csb1=1, web0=1, wmask0=0, addr0=0, addr1=0, din0=0, both req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSMs to IDLE, hold registers 0.
REQ-023 SHALL discard any accepted request or pending response when rst asserts mid-operation; no response emitted after reset release.
REQ-024 SHALL assert req_ready the first cycle after rst deasserts.

Verification
REQ-025 Write 0xDEADBEEF, be=4'hF, addr 0x10, then read 0x10 -> rsp_valid one cycle after each accept, read rdata=0xDEADBEEF, err=0.
REQ-026 Write 0x000000AA be=4'h1 to word holding 0x11223344, read back -> 0x112233AA.
REQ-027 Read with d_rsp_ready=0 for 3 cycles, then 1 -> rdata stable throughout, d_req_ready=0 during stall, single handshake.
REQ-028 d_ write 0x55 and i_ read of same address in same cycle -> i_req_ready=0 that cycle, fetch response next-next cycle returns 0x55.
REQ-029 Read of addr 0x00000400 -> csb0 stays 1, rsp err=1, rdata=0.
REQ-030 rst pulse while read response stalled -> rsp_valid=0, csb0=1 immediately; no stale response after release.
